// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: picks the next fetch PC from flush, return-address
// stack, predicted-taken target or the sequential successor.
module pc_sequencer #(
  parameter int            AW        = 32,
  parameter int            STEP      = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int            RAS_DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Flush,
  input  logic [AW-1:0]                FlushAddr,
  input  logic                         Stall,
  input  logic                         PredTaken,
  input  logic [AW-1:0]                PredAddr,
  input  logic                         PredCall,
  input  logic                         RetPredict,
  output logic [AW-1:0]                InstrAddr,
  output logic [AW-1:0]                NextSeq,
  output logic [1:0]                   RedirSrc,
  output logic [$clog2(RAS_DEPTH):0]   RasCount
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SRC_SEQ   = 2'd0;
  localparam logic [1:0] SRC_PRED  = 2'd1;
  localparam logic [1:0] SRC_RAS   = 2'd2;
  localparam logic [1:0] SRC_FLUSH = 2'd3;

  logic [AW-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_d;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] addr_d;
  logic [1:0]    src_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic          pop_ok;
  logic          push;

  assign NextSeq = InstrAddr + AW'(STEP);
  assign pop_ok  = RetPredict && (RasCount != '0);
  assign push    = PredTaken && PredCall;

  always_comb begin
    addr_d = InstrAddr;
    src_d  = RedirSrc;
    ptr_d  = ptr;
    cnt_d  = RasCount;
    wr_en  = 1'b0;
    wr_idx = ptr + PW'(1);
    if (Flush) begin
      addr_d = FlushAddr;
      src_d  = SRC_FLUSH;
      ptr_d  = '0;
      cnt_d  = '0;
    end else if (!Stall) begin
      if (pop_ok) begin
        addr_d = ras[ptr];
        src_d  = SRC_RAS;
      end else if (PredTaken) begin
        addr_d = PredAddr;
        src_d  = SRC_PRED;
      end else begin
        addr_d = NextSeq;
        src_d  = SRC_SEQ;
      end
      // Pop+push reuses the popped slot, so pointer and count stay put.
      case ({pop_ok, push})
        2'b11: begin
          wr_en  = 1'b1;
          wr_idx = ptr;
        end
        2'b10: begin
          ptr_d = ptr - PW'(1);
          cnt_d = RasCount - CW'(1);
        end
        2'b01: begin
          wr_en = 1'b1;
          ptr_d = ptr + PW'(1);
          if (RasCount != CW'(RAS_DEPTH))
            cnt_d = RasCount + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      InstrAddr <= RESET_VEC;
      RedirSrc  <= SRC_FLUSH;
      RasCount  <= '0;
      ptr       <= '0;
    end else begin
      InstrAddr <= addr_d;
      RedirSrc  <= src_d;
      RasCount  <= cnt_d;
      ptr       <= ptr_d;
    end
  end

  // Entry storage is not reset; RasCount alone decides which entries are live.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_en)
      ras[wr_idx] <= NextSeq;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, call/return, RAS overflow,
// stall/flush priority, address wrap and asynchronous reset.
module tb_pc_sequencer;

  localparam int AW = 32;

  logic          Clk;
  logic          Rst;
  logic          Flush;
  logic [AW-1:0] FlushAddr;
  logic          Stall;
  logic          PredTaken;
  logic [AW-1:0] PredAddr;
  logic          PredCall;
  logic          RetPredict;
  logic [AW-1:0] InstrAddr;
  logic [AW-1:0] NextSeq;
  logic [1:0]    RedirSrc;
  logic [2:0]    RasCount;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .AW(AW), .STEP(4), .RESET_VEC('0), .RAS_DEPTH(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .FlushAddr(FlushAddr), .Stall(Stall),
    .PredTaken(PredTaken), .PredAddr(PredAddr), .PredCall(PredCall),
    .RetPredict(RetPredict), .InstrAddr(InstrAddr), .NextSeq(NextSeq),
    .RedirSrc(RedirSrc), .RasCount(RasCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] addr,
                           input logic [1:0] src, input logic [2:0] cnt);
    chk({tag, " addr"}, InstrAddr, addr);
    chk({tag, " src"}, RedirSrc, src);
    chk({tag, " cnt"}, RasCount, cnt);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Flush = 0; FlushAddr = '0; Stall = 0; PredTaken = 0;
    PredAddr = '0; PredCall = 0; RetPredict = 0;
  endtask

  task automatic flush_to(input logic [31:0] a);
    idle();
    Flush = 1; FlushAddr = a;
    tick();
    idle();
  endtask

  task automatic call(input logic [31:0] target);
    idle();
    PredTaken = 1; PredCall = 1; PredAddr = target;
    tick();
    idle();
  endtask

  task automatic ret();
    idle();
    RetPredict = 1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    Rst = 1;
    #3;
    chk_state("por", 32'h0, 2'd3, 3'd0);
    repeat (2) tick();
    Rst = 0;
    chk_state("rst_hold", 32'h0, 2'd3, 3'd0);
    chk("rst_nextseq", NextSeq, 32'h4);

    // Idle sequential fetch
    tick(); chk_state("seq1", 32'h4, 2'd0, 3'd0);
    tick(); chk_state("seq2", 32'h8, 2'd0, 3'd0);
    tick(); chk_state("seq3", 32'hC, 2'd0, 3'd0);
    chk("seq3_nextseq", NextSeq, 32'h10);

    // Call then return
    flush_to(32'h100);
    chk_state("cr_flush", 32'h100, 2'd3, 3'd0);
    call(32'h400);
    chk_state("cr_call", 32'h400, 2'd1, 3'd1);
    tick(); chk_state("cr_s1", 32'h404, 2'd0, 3'd1);
    tick(); chk_state("cr_s2", 32'h408, 2'd0, 3'd1);
    ret();
    chk_state("cr_ret", 32'h104, 2'd2, 3'd0);

    // Five nested calls overflow a 4-deep stack
    flush_to(32'h10);
    call(32'h20); chk_state("ov_c1", 32'h20, 2'd1, 3'd1);
    call(32'h30); chk_state("ov_c2", 32'h30, 2'd1, 3'd2);
    call(32'h40); chk_state("ov_c3", 32'h40, 2'd1, 3'd3);
    call(32'h50); chk_state("ov_c4", 32'h50, 2'd1, 3'd4);
    call(32'h60); chk_state("ov_c5", 32'h60, 2'd1, 3'd4);
    ret(); chk_state("ov_r1", 32'h54, 2'd2, 3'd3);
    ret(); chk_state("ov_r2", 32'h44, 2'd2, 3'd2);
    ret(); chk_state("ov_r3", 32'h34, 2'd2, 3'd1);
    ret(); chk_state("ov_r4", 32'h24, 2'd2, 3'd0);
    ret(); chk_state("ov_r5", 32'h28, 2'd0, 3'd0);

    // Simultaneous pop and push
    call(32'h80); chk_state("pp_call", 32'h80, 2'd1, 3'd1);
    idle();
    RetPredict = 1; PredTaken = 1; PredCall = 1; PredAddr = 32'h900;
    tick(); idle();
    chk_state("pp_both", 32'h2C, 2'd2, 3'd1);
    ret(); chk_state("pp_ret", 32'h84, 2'd2, 3'd0);

    // PredCall alone, and RetPredict on an empty stack
    PredCall = 1;
    tick(); idle();
    chk_state("call_only", 32'h88, 2'd0, 3'd0);
    RetPredict = 1; PredTaken = 1; PredAddr = 32'h300;
    tick(); idle();
    chk_state("ret_empty", 32'h300, 2'd1, 3'd0);

    // Stall holds everything, Flush overrides Stall
    call(32'h500); chk_state("st_call", 32'h500, 2'd1, 3'd1);
    Stall = 1; PredTaken = 1; PredCall = 1; RetPredict = 1; PredAddr = 32'h777;
    tick(); chk_state("st1", 32'h500, 2'd1, 3'd1);
    tick(); chk_state("st2", 32'h500, 2'd1, 3'd1);
    tick(); chk_state("st3", 32'h500, 2'd1, 3'd1);
    Flush = 1; FlushAddr = 32'h2000;
    tick(); idle();
    chk_state("st_flush", 32'h2000, 2'd3, 3'd0);

    // Top-of-address-space wrap
    flush_to(32'hFFFF_FFFC);
    chk("wrap_nextseq", NextSeq, 32'h0);
    tick(); chk_state("wrap", 32'h0, 2'd0, 3'd0);

    // Asynchronous reset mid-operation with stall and live stack
    call(32'h40); chk_state("ar_c1", 32'h40, 2'd1, 3'd1);
    call(32'h80); chk_state("ar_c2", 32'h80, 2'd1, 3'd2);
    Stall = 1;
    tick(); chk_state("ar_stall", 32'h80, 2'd1, 3'd2);
    #2 Rst = 1;
    #1 chk_state("ar_async", 32'h0, 2'd3, 3'd0);
    Flush = 1; FlushAddr = 32'h1234;
    tick(); chk_state("ar_held", 32'h0, 2'd3, 3'd0);
    idle();
    Rst = 0;
    tick(); chk_state("ar_first", 32'h4, 2'd0, 3'd0);
    call(32'h200); chk_state("ar_call", 32'h200, 2'd1, 3'd1);
    ret(); chk_state("ar_ret", 32'h8, 2'd2, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter STEP, default 4, sequential fetch increment in bytes.
REQ-003 Parameter RESET_VEC, default 0, fetch address loaded on reset (AW bits).
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >= 2.
REQ-005 Clk  in  1  single clock; all state updates on rising edge.
REQ-006 Rst  in  1  reset, asynchronous, active-high.
REQ-007 Flush  in  1  pipeline flush; redirect to FlushAddr.
REQ-008 FlushAddr  in  AW  resolved redirect target.
REQ-009 Stall  in  1  hold fetch address and all state.
REQ-010 PredTaken  in  1  branch predictor: current fetch slot is predicted taken.
REQ-011 PredAddr  in  AW  predicted taken target.
REQ-012 PredCall  in  1  predicted-taken slot is a call; push return address (qualified by PredTaken).
REQ-013 RetPredict  in  1  current fetch slot is a return; target taken from RAS top.
REQ-014 InstrAddr  out  AW  registered current fetch address.
REQ-015 NextSeq  out  AW  combinational InstrAddr + STEP.
REQ-016 RedirSrc  out  2  registered source of current InstrAddr: 0 seq, 1 pred, 2 RAS, 3 flush/reset.
REQ-017 RasCount  out  clog2(RAS_DEPTH)+1  registered number of valid RAS entries.

Function
REQ-018 NextSeq SHALL equal (InstrAddr + STEP) modulo 2^AW; wrap-around from top of address space to low addresses is legal and silent.
REQ-019 Next InstrAddr SHALL be chosen by strict priority: Flush > Stall > (RetPredict and RasCount>0) > PredTaken > sequential.
REQ-020 Flush: InstrAddr <= FlushAddr, RedirSrc <= 3, RasCount <= 0, RAS top pointer <= 0; Flush overrides Stall, RetPredict, PredTaken, PredCall in the same cycle.
REQ-021 Stall (no Flush): InstrAddr, RedirSrc, RAS contents, pointer and RasCount SHALL hold; all predictor inputs ignored.
REQ-022 Return (RetPredict, RasCount>0): InstrAddr <= RAS top entry, RedirSrc <= 2, pop (pointer decrement mod RAS_DEPTH, RasCount-1).
REQ-023 Return with RasCount=0: no pop, RetPredict ignored; selection falls through to PredTaken or sequential.
REQ-024 Predicted taken (no higher-priority event): InstrAddr <= PredAddr, RedirSrc <= 1.
REQ-025 Sequential: InstrAddr <= NextSeq, RedirSrc <= 0.
REQ-026 Push: when PredTaken and PredCall and no Flush/Stall, NextSeq SHALL be written to RAS at pointer+1 (mod RAS_DEPTH), pointer advances; push occurs even if a return won target selection.
REQ-027 Push with RasCount=RAS_DEPTH: oldest entry overwritten circularly, RasCount saturates at RAS_DEPTH.
REQ-028 Simultaneous valid pop and push: popped entry supplies target, then NextSeq replaces that slot; pointer and RasCount unchanged.
REQ-029 PredCall without PredTaken SHALL have no effect.
REQ-030 Latency: every selection takes effect on InstrAddr exactly one Clk edge after inputs sampled; no combinational path from inputs to InstrAddr, RedirSrc or RasCount.

Reset
REQ-031 Rst assertion SHALL immediately, independent of Clk, force InstrAddr=RESET_VEC, RedirSrc=3, RasCount=0, RAS pointer=0; RAS entry storage need not be cleared.
REQ-032 While Rst high all inputs ignored; first update occurs on the first rising Clk after Rst deasserts, per REQ-019.
REQ-033 Rst asserted mid-operation (during Stall or with full RAS) SHALL discard all in-flight state identically to power-on reset.

Verification
REQ-034 Reset then 3 idle cycles (defaults) -> InstrAddr 0x0,0x4,0x8,0xC; RedirSrc 3,0,0,0; NextSeq tracks +4.
REQ-035 At InstrAddr 0x100 assert PredTaken+PredCall, PredAddr 0x400; later at 0x408 assert RetPredict -> InstrAddr 0x400 (RedirSrc 1, RasCount 1), then 0x104 (RedirSrc 2, RasCount 0).
REQ-036 Five calls with RAS_DEPTH 4 from 0x10,0x20,0x30,0x40,0x50 (each PredAddr to next caller) then five returns -> return targets 0x54,0x44,0x34,0x24, then fifth return falls to sequential; RasCount 4,4,3,2,1,0.
REQ-037 Stall held 3 cycles with PredTaken asserted, then Flush with Stall still high and FlushAddr 0x2000 -> InstrAddr unchanged for 3 edges, then 0x2000, RedirSrc 3, RasCount 0.
REQ-038 InstrAddr 0xFFFFFFFC, no events -> next InstrAddr 0x00000000, RedirSrc 0.
REQ-039 Rst pulsed between Clk edges while RasCount 2 and Stall high -> InstrAddr RESET_VEC and RasCount 0 before next Clk edge.
